fuzz_stim_sequencer: RTL and testbench

Stimulus and response controller for a fuzz-generated DUT under simulator differential testing. It drives the DUT's packed input bus from a seeded 32-bit Galois LFSR for a programmed number of vectors. It compacts the DUT's packed output bus into a MISR signature, so two simulators can be compared on a single word. It sits beside the DUT in the simulation harness, on the same clock.

---
 rtl/fuzz_stim_sequencer_if.sv | 28 ++
 rtl/fuzz_stim_sequencer.sv | 137 +++++++++++++
 tb/tb_fuzz_stim_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fuzz_stim_sequencer_if.sv
// Handshake and data bundle between the fuzz stimulus sequencer and its harness.
// The slave modport belongs to the sequencer; the master modport belongs to the harness side.
interface fuzz_stim_sequencer_if #(
    parameter int unsigned IN_W = 68,
    parameter int unsigned Y_W  = 82
);
    logic            start;
    logic            abort;
    logic [31:0]     seed;
    logic [15:0]     num_vec;
    logic [IN_W-1:0] dut_in;
    logic            dut_valid;
    logic [Y_W-1:0]  y_in;
    logic            busy;
    logic            done;
    logic [Y_W-1:0]  signature;
    logic [15:0]     vec_cnt;

    modport master (
        output start, abort, seed, num_vec, y_in,
        input  dut_in, dut_valid, busy, done, signature, vec_cnt
    );

    modport slave (
        input  start, abort, seed, num_vec, y_in,
        output dut_in, dut_valid, busy, done, signature, vec_cnt
    );
endinterface

// File: rtl/fuzz_stim_sequencer.sv
// LFSR-driven stimulus generator and MISR response compactor for differential fuzz runs.
// Applies num_vec pseudo-random vectors, then compacts LAT-delayed DUT outputs into a signature.
module fuzz_stim_sequencer #(
    parameter int unsigned IN_W      = 68,
    parameter int unsigned Y_W       = 82,
    parameter int unsigned LAT       = 1,
    parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
    input logic                  clk,
    input logic                  rst,
    fuzz_stim_sequencer_if.slave io_bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [31:0]     r_lfsr;
    logic [31:0]     w_lfsr_d;
    logic [IN_W-1:0] r_dut_in;
    logic [IN_W-1:0] w_dut_in_d;
    logic            r_dut_valid;
    logic            w_dut_valid_d;
    logic [Y_W-1:0]  r_sig;
    logic [Y_W-1:0]  w_sig_d;
    logic [15:0]     r_vec_cnt;
    logic [15:0]     w_vec_cnt_d;
    logic [15:0]     r_num_vec;
    logic [15:0]     w_num_vec_d;
    logic [LAT-1:0]  r_cap;
    logic [LAT-1:0]  w_cap_d;

    logic [31:0]     w_lfsr_step;
    logic [31:0]     w_seed_eff;
    logic [15:0]     w_cnt_inc;
    logic            w_cap_en;
    logic            w_pipe_empty;

    assign w_lfsr_step  = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_POLY) : (r_lfsr >> 1);
    // An all-zero Galois LFSR never leaves zero, so a zero seed is remapped.
    assign w_seed_eff   = (io_bus.seed == 32'd0) ? 32'h1 : io_bus.seed;
    assign w_cnt_inc    = r_vec_cnt + 16'd1;
    assign w_cap_en     = r_cap[LAT-1];
    assign w_pipe_empty = !r_dut_valid && (r_cap == '0);

    always_comb begin
        w_state_d     = r_state;
        w_lfsr_d      = r_lfsr;
        w_dut_in_d    = r_dut_in;
        w_dut_valid_d = 1'b0;
        w_sig_d       = r_sig;
        w_vec_cnt_d   = r_vec_cnt;
        w_num_vec_d   = r_num_vec;
        w_cap_d       = (r_cap << 1) | LAT'(r_dut_valid);

        if (w_cap_en) begin
            w_sig_d = {r_sig[Y_W-2:0], r_sig[Y_W-1]} ^ io_bus.y_in;
        end

        unique case (r_state)
            StIdle, StDone: begin
                if (io_bus.start) begin
                    w_lfsr_d    = w_seed_eff;
                    w_sig_d     = '0;
                    w_vec_cnt_d = '0;
                    w_dut_in_d  = '0;
                    w_cap_d     = '0;
                    w_num_vec_d = io_bus.num_vec;
                    w_state_d   = (io_bus.num_vec != 16'd0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (io_bus.abort) begin
                    w_sig_d   = r_sig;
                    w_cap_d   = '0;
                    w_state_d = StIdle;
                end else begin
                    w_lfsr_d      = w_lfsr_step;
                    // Shift form keeps this legal for IN_W == 32 as well.
                    w_dut_in_d    = (r_dut_in << 32) | IN_W'(w_lfsr_step);
                    w_dut_valid_d = 1'b1;
                    w_vec_cnt_d   = w_cnt_inc;
                    if (w_cnt_inc == r_num_vec) begin
                        w_state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (io_bus.abort) begin
                    w_sig_d   = r_sig;
                    w_cap_d   = '0;
                    w_state_d = StIdle;
                end else if (w_pipe_empty) begin
                    w_state_d = StDone;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_lfsr      <= 32'h1;
            r_dut_in    <= '0;
            r_dut_valid <= 1'b0;
            r_sig       <= '0;
            r_vec_cnt   <= '0;
            r_num_vec   <= '0;
            r_cap       <= '0;
        end else begin
            r_state     <= w_state_d;
            r_lfsr      <= w_lfsr_d;
            r_dut_in    <= w_dut_in_d;
            r_dut_valid <= w_dut_valid_d;
            r_sig       <= w_sig_d;
            r_vec_cnt   <= w_vec_cnt_d;
            r_num_vec   <= w_num_vec_d;
            r_cap       <= w_cap_d;
        end
    end

    assign io_bus.dut_in    = r_dut_in;
    assign io_bus.dut_valid = r_dut_valid;
    assign io_bus.signature = r_sig;
    assign io_bus.vec_cnt   = r_vec_cnt;
    assign io_bus.busy      = (r_state == StRun) || (r_state == StDrain);
    assign io_bus.done      = (r_state == StDone);

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Scoreboard bench for fuzz_stim_sequencer: a reference model queues expected vectors and final
// signatures; independent monitors compare them as the sequencer presents them.
module tb_fuzz_stim_sequencer;

    localparam int unsigned IN_W = 68;
    localparam int unsigned Y_W  = 82;
    localparam int unsigned LAT  = 1;
    localparam logic [31:0] POLY = 32'h80200003;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fuzz_stim_sequencer_if #(.IN_W(IN_W), .Y_W(Y_W)) bus ();

    fuzz_stim_sequencer #(
        .IN_W(IN_W),
        .Y_W(Y_W),
        .LAT(LAT),
        .LFSR_POLY(POLY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [IN_W-1:0] vec_q[$];
    logic [Y_W-1:0]  sig_q[$];
    logic [15:0]     cnt_q[$];
    logic [Y_W-1:0]  trace_q[$];

    bit             y_const  = 1'b0;
    bit             trace_on = 1'b0;
    logic [Y_W-1:0] y_reg    = '0;
    logic [Y_W-1:0] sig_prev = '0;
    bit             done_prev = 1'b0;

    task automatic check(input string name, input logic [Y_W-1:0] act, input logic [Y_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stand-in for the fuzzed design: one register stage from dut_in to y.
    function automatic logic [Y_W-1:0] fake_dut(input logic [IN_W-1:0] v);
        return {v[13:0] ^ 14'h2A5A, v ^ {v[33:0], v[67:34]}};
    endfunction

    always @(posedge clk) y_reg <= y_const ? Y_W'(1) : fake_dut(bus.dut_in);
    assign bus.y_in = y_reg;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    endfunction

    // Queues the first n_issue vectors; returns the MISR after n_comp compactions.
    task automatic model_run(input logic [31:0] seed, input int n_issue, input int n_comp,
                             output logic [Y_W-1:0] sig);
        logic [31:0]     l;
        logic [IN_W-1:0] v;
        logic [Y_W-1:0]  y;
        l   = (seed == 32'd0) ? 32'h1 : seed;
        v   = '0;
        sig = '0;
        for (int i = 0; i < n_issue; i++) begin
            l = lfsr_next(l);
            v = (v << 32) | IN_W'(l);
            vec_q.push_back(v);
            if (i < n_comp) begin
                y   = y_const ? Y_W'(1) : fake_dut(v);
                sig = ((sig << 1) | (sig >> (Y_W - 1))) ^ y;
            end
        end
    endtask

    task automatic drive_start(input logic [31:0] seed, input logic [15:0] n);
        @(negedge clk);
        bus.seed    = seed;
        bus.num_vec = n;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic launch(input logic [31:0] seed, input logic [15:0] n, input bit expect_done);
        logic [Y_W-1:0] s;
        model_run(seed, int'(n), int'(n), s);
        if (expect_done) begin
            sig_q.push_back(s);
            cnt_q.push_back(n);
        end
        drive_start(seed, n);
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (!bus.done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, Y_W'(bus.done), Y_W'(1));
    endtask

    always @(negedge clk) begin
        if (!rst && bus.dut_valid) begin
            if (vec_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL vec_unexpected: got dut_in %0h expected no vector", bus.dut_in);
            end else begin
                check("dut_in", Y_W'(bus.dut_in), Y_W'(vec_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (bus.done && !done_prev) begin
            if (sig_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_unexpected: got signature %0h expected no completion",
                         bus.signature);
            end else begin
                check("final_signature", bus.signature, sig_q.pop_front());
                check("final_vec_cnt", Y_W'(bus.vec_cnt), Y_W'(cnt_q.pop_front()));
            end
        end
        done_prev = bus.done;
    end

    always @(negedge clk) begin
        if (trace_on && bus.signature !== sig_prev && bus.signature != '0) begin
            trace_q.push_back(bus.signature);
        end
        sig_prev = bus.signature;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected bench end");
        $fatal(1);
    end

    initial begin
        logic [Y_W-1:0]  s_ab;
        logic [Y_W-1:0]  seq_exp[3];
        logic [IN_W-1:0] first_vec;
        int              nc;
        logic [31:0]     rs;
        logic [15:0]     rn;

        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.seed    = '0;
        bus.num_vec = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_busy", Y_W'(bus.busy), '0);
        check("rst_done", Y_W'(bus.done), '0);
        check("rst_valid", Y_W'(bus.dut_valid), '0);
        check("rst_dut_in", Y_W'(bus.dut_in), '0);
        check("rst_sig", bus.signature, '0);
        check("rst_vec_cnt", Y_W'(bus.vec_cnt), '0);

        // Zero-length run goes straight to DONE.
        launch(32'h1234_5678, 16'd0, 1'b1);
        check("nv0_done", Y_W'(bus.done), Y_W'(1));
        check("nv0_busy", Y_W'(bus.busy), '0);
        check("nv0_vec_cnt", Y_W'(bus.vec_cnt), '0);
        check("nv0_sig", bus.signature, '0);
        check("nv0_valid", Y_W'(bus.dut_valid), '0);

        // Zero seed behaves as seed 1.
        launch(32'h0, 16'd1, 1'b1);
        @(negedge clk);
        first_vec = IN_W'(32'h80200003);
        check("seed0_valid", Y_W'(bus.dut_valid), Y_W'(1));
        check("seed0_vec", Y_W'(bus.dut_in), Y_W'(first_vec));
        wait_done("seed0_done", 100);

        // Constant y=1 gives signature steps 1, 3, 7.
        y_const = 1'b1;
        trace_q.delete();
        trace_on = 1'b1;
        launch(32'hACE1, 16'd3, 1'b1);
        wait_done("ones_done", 100);
        trace_on = 1'b0;
        seq_exp[0] = Y_W'(1);
        seq_exp[1] = Y_W'(3);
        seq_exp[2] = Y_W'(7);
        check("ones_steps", Y_W'(trace_q.size()), Y_W'(3));
        for (int i = 0; i < 3; i++) begin
            check("ones_step", (i < trace_q.size()) ? trace_q[i] : 'x, seq_exp[i]);
        end
        check("ones_final", bus.signature, Y_W'(7));
        y_const = 1'b0;
        @(negedge clk);

        // Abort two cycles into a 10-vector run: vectors from edges 1 and 2 only.
        nc = 2 - int'(LAT) - 1;
        if (nc < 0) nc = 0;
        model_run(32'hBEEF_0001, 2, nc, s_ab);
        drive_start(32'hBEEF_0001, 16'd10);
        @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", Y_W'(bus.busy), '0);
        check("abort_valid", Y_W'(bus.dut_valid), '0);
        check("abort_done", Y_W'(bus.done), '0);
        check("abort_vec_cnt", Y_W'(bus.vec_cnt), Y_W'(2));
        check("abort_sig", bus.signature, s_ab);
        repeat (3) @(negedge clk);
        check("abort_frozen_cnt", Y_W'(bus.vec_cnt), Y_W'(2));
        launch(32'h0BAD_CAFE, 16'd2, 1'b1);
        wait_done("after_abort_done", 100);
        check("after_abort_cnt", Y_W'(bus.vec_cnt), Y_W'(2));

        // A start pulse while busy is ignored.
        launch(32'h1357_9BDF, 16'd20, 1'b1);
        repeat (5) @(negedge clk);
        bus.seed    = 32'hFFFF_0000;
        bus.num_vec = 16'd7;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        wait_done("busy_start_done", 200);
        check("busy_start_cnt", Y_W'(bus.vec_cnt), Y_W'(20));

        for (int r = 0; r < 8; r++) begin
            rs = $urandom;
            rn = 16'($urandom_range(1, 40));
            launch(rs, rn, 1'b1);
            wait_done("rand_done", 300);
        end

        // Asynchronous reset between clock edges in the middle of a run.
        launch(32'h2468_ACE0, 16'd30, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", Y_W'(bus.busy), '0);
        check("arst_done", Y_W'(bus.done), '0);
        check("arst_valid", Y_W'(bus.dut_valid), '0);
        check("arst_dut_in", Y_W'(bus.dut_in), '0);
        check("arst_sig", bus.signature, '0);
        vec_q.delete();
        @(negedge clk);
        rst = 1'b0;
        launch(32'h5A5A_A5A5, 16'd5, 1'b1);
        wait_done("arst_restart_done", 100);

        repeat (2) @(negedge clk);
        check("vec_q_empty", Y_W'(vec_q.size()), '0);
        check("sig_q_empty", Y_W'(sig_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
